// File: rtl/gayle_ide_arbiter.sv
// gayle_ide_arbiter
// Grants host management access to one of the two Gayle IDE channels at a
// time. Ties are broken round robin. Host reads and writes are forwarded only
// to the granted channel. The grant ends on host completion, on request
// withdrawal or on timeout, and is always followed by one idle GAP cycle.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_ide_req[5:0]      request levels, [2:0] channel 0, [5:3] channel 1
//   i_host_*            host management access (address, strobes, data, done)
//   o_ide_*             forwarded access, address = {grant_chan, host_address}
//   o_grant_valid/chan  current grant
//   o_grant_req         request bits of the granted channel, latched at grant
//   o_host_irq          pulse on each new grant
//   o_drop_err          pulse when a host access is discarded
//   o_tmo               pulse on grant timeout
module gayle_ide_arbiter #(
  parameter int unsigned TMO_W = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_ide_req,
  input  logic [3:0]  i_host_address,
  input  logic        i_host_write,
  input  logic        i_host_read,
  input  logic [15:0] i_host_writedata,
  input  logic        i_host_done,
  output logic [4:0]  o_ide_address,
  output logic        o_ide_write,
  output logic        o_ide_read,
  output logic [15:0] o_ide_writedata,
  output logic        o_grant_valid,
  output logic        o_grant_chan,
  output logic [2:0]  o_grant_req,
  output logic        o_host_irq,
  output logic        o_drop_err,
  output logic        o_tmo
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  localparam logic [TMO_W-1:0] CntMax = '1;

  state_e            r_state, w_state_d;
  logic              r_last_chan, w_last_chan_d;
  logic [TMO_W-1:0]  r_cnt, w_cnt_d;
  logic [4:0]        r_ide_address, w_ide_address_d;
  logic [15:0]       r_ide_writedata, w_ide_writedata_d;
  logic              r_ide_write, w_ide_write_d;
  logic              r_ide_read, w_ide_read_d;
  logic              r_grant_valid, w_grant_valid_d;
  logic              r_grant_chan, w_grant_chan_d;
  logic [2:0]        r_grant_req, w_grant_req_d;
  logic              r_host_irq, w_host_irq_d;
  logic              r_drop_err, w_drop_err_d;
  logic              r_tmo, w_tmo_d;

  logic              w_pend0, w_pend1, w_pick, w_access, w_withdraw, w_timeout;
  logic [2:0]        w_pick_req;
  logic [TMO_W-1:0]  w_cnt_inc;

  assign w_pend0    = |i_ide_req[2:0];
  assign w_pend1    = |i_ide_req[5:3];
  // Both pending: pick the channel not served last time.
  assign w_pick     = (w_pend0 && w_pend1) ? ~r_last_chan : w_pend1;
  assign w_pick_req = w_pick ? i_ide_req[5:3] : i_ide_req[2:0];
  assign w_access   = i_host_write | i_host_read;
  assign w_withdraw = r_grant_chan ? ~|i_ide_req[5:3] : ~|i_ide_req[2:0];
  assign w_cnt_inc  = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;
  // Fires on the BUSY cycle that brings the counter to all-ones.
  assign w_timeout  = (w_cnt_inc == CntMax);

  always_comb begin
    w_state_d         = r_state;
    w_last_chan_d     = r_last_chan;
    w_cnt_d           = r_cnt;
    w_ide_address_d   = r_ide_address;
    w_ide_writedata_d = r_ide_writedata;
    w_ide_write_d     = 1'b0;
    w_ide_read_d      = 1'b0;
    w_grant_valid_d   = r_grant_valid;
    w_grant_chan_d    = r_grant_chan;
    w_grant_req_d     = r_grant_req;
    w_host_irq_d      = 1'b0;
    w_drop_err_d      = 1'b0;
    w_tmo_d           = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_drop_err_d = w_access;
        if (w_pend0 || w_pend1) begin
          w_state_d       = StBusy;
          w_grant_valid_d = 1'b1;
          w_grant_chan_d  = w_pick;
          w_grant_req_d   = w_pick_req;
          w_last_chan_d   = w_pick;
          w_cnt_d         = '0;
          w_host_irq_d    = 1'b1;
        end
      end
      StBusy: begin
        w_cnt_d = w_cnt_inc;
        // Write wins a simultaneous read; the read counts as dropped.
        if (i_host_write) begin
          w_ide_write_d     = 1'b1;
          w_ide_address_d   = {r_grant_chan, i_host_address};
          w_ide_writedata_d = i_host_writedata;
        end else if (i_host_read) begin
          w_ide_read_d    = 1'b1;
          w_ide_address_d = {r_grant_chan, i_host_address};
        end
        w_drop_err_d = i_host_write & i_host_read;
        if (i_host_done || w_withdraw || w_timeout) begin
          w_state_d       = StGap;
          w_grant_valid_d = 1'b0;
          w_tmo_d         = w_timeout & ~i_host_done & ~w_withdraw;
        end
      end
      StGap: begin
        w_drop_err_d = w_access;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_last_chan     <= 1'b1;
      r_cnt           <= '0;
      r_ide_address   <= '0;
      r_ide_writedata <= '0;
      r_ide_write     <= 1'b0;
      r_ide_read      <= 1'b0;
      r_grant_valid   <= 1'b0;
      r_grant_chan    <= 1'b0;
      r_grant_req     <= '0;
      r_host_irq      <= 1'b0;
      r_drop_err      <= 1'b0;
      r_tmo           <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_last_chan     <= w_last_chan_d;
      r_cnt           <= w_cnt_d;
      r_ide_address   <= w_ide_address_d;
      r_ide_writedata <= w_ide_writedata_d;
      r_ide_write     <= w_ide_write_d;
      r_ide_read      <= w_ide_read_d;
      r_grant_valid   <= w_grant_valid_d;
      r_grant_chan    <= w_grant_chan_d;
      r_grant_req     <= w_grant_req_d;
      r_host_irq      <= w_host_irq_d;
      r_drop_err      <= w_drop_err_d;
      r_tmo           <= w_tmo_d;
    end
  end

  assign o_ide_address   = r_ide_address;
  assign o_ide_writedata = r_ide_writedata;
  assign o_ide_write     = r_ide_write;
  assign o_ide_read      = r_ide_read;
  assign o_grant_valid   = r_grant_valid;
  assign o_grant_chan    = r_grant_chan;
  assign o_grant_req     = r_grant_req;
  assign o_host_irq      = r_host_irq;
  assign o_drop_err      = r_drop_err;
  assign o_tmo           = r_tmo;

endmodule

// File: doc/gayle_ide_arbiter.md
# gayle_ide_arbiter

Schedules host-side (management) servicing of the two Gayle IDE channels. It watches the 6-bit request vector raised by the two IDE task-file engines and grants one channel at a time to the host. It then forwards host management reads and writes to the granted channel only, and releases the grant on host completion, request withdrawal or timeout. It sits between the Gayle IDE request/management port and the host (HPS) bridge, and alternates fairly between channels.

## Interface
Parameters:
- TMO_W, 20, width of the grant timeout counter; timeout fires after 2^TMO_W − 1 cycles in BUSY.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- ide_req  in  6  request levels; [2:0] channel 0, [5:3] channel 1; any nonzero bit = channel pending
- host_address  in  4  host management register address
- host_write  in  1  host write strobe, one cycle per access
- host_read  in  1  host read strobe, one cycle per access
- host_writedata  in  16  host write data
- host_done  in  1  one-cycle pulse: host finished servicing current grant
- ide_address  out  5  {granted channel, host_address}
- ide_write  out  1  forwarded write strobe
- ide_read  out  1  forwarded read strobe
- ide_writedata  out  16  forwarded write data
- grant_valid  out  1  a channel is granted (BUSY)
- grant_chan  out  1  granted channel number
- grant_req  out  3  request bits of granted channel, latched at grant
- host_irq  out  1  one-cycle pulse on each new grant
- drop_err  out  1  one-cycle pulse when a host access is discarded
- tmo  out  1  one-cycle pulse on grant timeout

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: pend0 = |ide_req[2:0], pend1 = |ide_req[5:3]. If neither, stay. If exactly one, grant it. If both, grant channel != last_chan (round robin); last_chan resets to 1, so channel 0 wins the first tie. On grant: grant_chan, grant_req latched, last_chan <= granted, timeout counter cleared, host_irq pulsed, go BUSY.
- BUSY: host_read/host_write forwarded as ide_read/ide_write with ide_address = {grant_chan, host_address} and ide_writedata = host_writedata. Exit to GAP on the first of:
  - host_done
  - granted channel's request bits all zero (withdrawal)
  - counter reaching all-ones (pulse tmo)
- Simultaneous exit conditions in one cycle: single exit, tmo pulses only if neither host_done nor withdrawal is present.
- An access in the same cycle as host_done is still forwarded.
- GAP: one cycle, grant_valid low, no forwarding, then IDLE. This guarantees a new arbitration even when the same channel stays pending.
- Host access in IDLE or GAP: not forwarded; drop_err pulses.
- host_read and host_write both high: write takes priority, read dropped, drop_err pulses.
- Counter: TMO_W bits, increments each BUSY cycle, saturates; it does not reset on accesses.
- Read data path is outside this block. The host samples ide_readdata via the existing channel mux, using ide_address[4].

## Timing
- All outputs are registered.
- Reset values:
  - ide_address = 0, ide_write = 0, ide_read = 0, ide_writedata = 0
  - grant_valid = 0, grant_chan = 0, grant_req = 0
  - host_irq = 0, drop_err = 0, tmo = 0
  - state IDLE, last_chan = 1, counter 0
- Reset low mid-BUSY: next cycle IDLE, strobes low, no tmo/drop_err pulse.
- Grant latency: request seen at edge N in IDLE → grant_valid, grant_chan and host_irq high after edge N+1.
- Forwarding latency: host strobe at edge N → ide strobe high for exactly one cycle after edge N+1, address and data aligned.
- Release: exit condition at edge N → grant_valid low after N+1 (GAP). Earliest re-grant is after N+3.
- grant_req is stable throughout BUSY even if ide_req changes.

## Test plan
- Reset, ide_req=6'b000_001 → one cycle later grant_valid=1, grant_chan=0, grant_req=3'b001, host_irq single pulse. host_write with address 4'h3 → ide_write one cycle, ide_address=5'h03.
- Both channels pending (6'b010_001), host_done after each grant → grants alternate 0,1,0,1, each separated by one idle GAP cycle.
- Grant channel 1, then ide_req[5:3]→0 → grant_valid drops next cycle, no tmo. host_read during GAP → drop_err pulse, no ide_read.
- TMO_W=4, hold grant with no host_done → tmo pulses after 15 BUSY cycles, channel 1 (pending) granted next.
- host_write and host_read in the same cycle while BUSY → only ide_write asserted, drop_err=1.
- rst_n low for one cycle mid-BUSY with ide_req held → outputs at reset values, then channel 0 re-granted 2 cycles after rst_n rises.
